// File: rtl/conv1x1_stream_engine_if.sv
// ---------------------------------------------------------------------------
// conv1x1_stream_engine_if
//
// Bundles the frame-control handshake, the input pixel stream, the weight
// ROM lookup, the bias vector and the output strobe of the 1x1 convolution
// engine.
//
// Parameters:
//   WIDTH   pixel / weight / output word width
//   DSP_NO  number of output channels (parallel MAC lanes)
//   CHIN    input channels per output pixel (sets the ROM address width)
//
// Signals:
//   start      frame start pulse            (master -> slave)
//   ifm_valid  pixel beat valid             (master -> slave)
//   ifm        signed input pixel           (master -> slave)
//   ifm_ready  engine accepts beats         (slave  -> master)
//   rom_addr   weight ROM address           (slave  -> master)
//   rom_data   DSP_NO kernel words          (master -> slave, combinational)
//   bias       DSP_NO 2*WIDTH biases        (master -> slave)
//   ofm        DSP_NO quantised outputs     (slave  -> master)
//   ofm_valid  one-cycle output strobe      (slave  -> master)
//   busy       frame in progress            (slave  -> master)
//   done       one-cycle end-of-frame pulse (slave  -> master)
//
// Modports: master = environment feeding the engine, slave = the engine.
// ---------------------------------------------------------------------------
interface conv1x1_stream_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 368,
    parameter int CHIN   = 112
);
    localparam int ADDR_W = (CHIN > 1) ? $clog2(CHIN) : 1;

    logic                               start;
    logic                               ifm_valid;
    logic [WIDTH-1:0]                   ifm;
    logic                               ifm_ready;
    logic [ADDR_W-1:0]                  rom_addr;
    logic [DSP_NO-1:0][WIDTH-1:0]       rom_data;
    logic [DSP_NO-1:0][2*WIDTH-1:0]     bias;
    logic [DSP_NO-1:0][WIDTH-1:0]       ofm;
    logic                               ofm_valid;
    logic                               busy;
    logic                               done;

    modport master (
        output start, ifm_valid, ifm, rom_data, bias,
        input  ifm_ready, rom_addr, ofm, ofm_valid, busy, done
    );

    modport slave (
        input  start, ifm_valid, ifm, rom_data, bias,
        output ifm_ready, rom_addr, ofm, ofm_valid, busy, done
    );
endinterface

// File: rtl/conv1x1_stream_engine.sv
// ---------------------------------------------------------------------------
// conv1x1_stream_engine
//
// 1x1 convolution engine for squeeze/expand layers. Pixels arrive
// channel-major, CHIN beats per output pixel. Every accepted beat is
// multiplied against DSP_NO kernel words read from a combinational weight
// ROM addressed by the current channel index and accumulated on top of a
// per-filter bias. After the last channel of a pixel the DSP_NO sums are
// passed through ReLU and saturating requantisation and presented on ofm
// with a one-cycle ofm_valid strobe. A frame is WOUT*WOUT output pixels,
// framed by start / busy / done.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   conv1x1_stream_engine_if.slave (stream, ROM, bias, output, control)
//
// Optional build macro:
//   CONV1X1_ROUND_EN  round half-up during requantisation instead of
//                     truncating; latency and handshakes are unchanged.
//
// Pipeline (edge E0 accepts a beat):
//   E0  stage 1 captures pixel, kernel words, first/last flags
//   E1  stage 2 multiply-accumulate into acc
//   E2  stage 3 quantises acc of a completed pixel
//   E3  output register drives ofm / ofm_valid / done
// ---------------------------------------------------------------------------
module conv1x1_stream_engine #(
    parameter int WIDTH     = 16,
    parameter int DSP_NO    = 368,
    parameter int CHIN      = 112,
    parameter int WOUT      = 8,
    parameter int FRAC_BITS = 14,
    parameter int ACC_WIDTH = 40
) (
    input logic                    clk,
    input logic                    rst,
    conv1x1_stream_engine_if.slave bus
);

    localparam int ADDR_W = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam int NPIX   = WOUT * WOUT;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        (ACC_WIDTH+1)'((1 << (WIDTH-1)) - 1);

`ifdef CONV1X1_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] ROUND_HALF =
        (ACC_WIDTH+1)'(1) << (FRAC_BITS-1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                              state;
    logic                                ifm_ready_q;
    logic                                busy_q;
    logic [ADDR_W-1:0]                   ch;
    logic [PIX_W-1:0]                    pix;
    logic                                accept;
    logic                                ch_last;
    logic                                pix_last;

    logic                                s1_valid;
    logic                                s1_first;
    logic                                s1_last;
    logic                                s1_frame_last;
    logic [WIDTH-1:0]                    s1_ifm;
    logic [DSP_NO-1:0][WIDTH-1:0]        s1_ker;

    logic signed [ACC_WIDTH-1:0]         acc      [DSP_NO];
    logic signed [ACC_WIDTH-1:0]         acc_next [DSP_NO];
    logic                                s2_valid;
    logic                                s2_frame_last;

    logic [DSP_NO-1:0][WIDTH-1:0]        q_next;
    logic [DSP_NO-1:0][WIDTH-1:0]        q_reg;
    logic                                s3_valid;
    logic                                s3_frame_last;

    logic [DSP_NO-1:0][WIDTH-1:0]        ofm_q;
    logic                                ofm_valid_q;
    logic                                done_q;

    // One multiply-accumulate step for a single lane. A first beat starts
    // from the sign-extended bias, which also discards the previous pixel's
    // sum without a dedicated clear cycle.
    function automatic logic signed [ACC_WIDTH-1:0] mac_step(
        input logic signed [ACC_WIDTH-1:0] acc_in,
        input logic                        first,
        input logic [2*WIDTH-1:0]          b,
        input logic [WIDTH-1:0]            px,
        input logic [WIDTH-1:0]            kw
    );
        logic signed [2*WIDTH-1:0]   prod;
        logic signed [ACC_WIDTH-1:0] prod_ext;
        logic signed [ACC_WIDTH-1:0] base;
        prod     = $signed(px) * $signed(kw);
        prod_ext = ACC_WIDTH'(prod);
        base     = first ? ACC_WIDTH'($signed(b)) : acc_in;
        return base + prod_ext;
    endfunction

    // Requantise one accumulator: optional half-up rounding, then ReLU,
    // then clamp to the largest positive output word. The extra top bit
    // keeps the rounding add from wrapping.
    function automatic logic [WIDTH-1:0] quantise(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH:0] v;
        logic signed [ACC_WIDTH:0] sh;
        v = (ACC_WIDTH+1)'(a);
`ifdef CONV1X1_ROUND_EN
        v = v + ROUND_HALF;
`endif
        sh = v >>> FRAC_BITS;
        if (v[ACC_WIDTH]) begin
            return '0;
        end else if (sh > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else begin
            return sh[WIDTH-1:0];
        end
    endfunction

    assign accept   = bus.ifm_valid && ifm_ready_q;
    assign ch_last  = (ch == ADDR_W'(CHIN - 1));
    assign pix_last = (pix == PIX_W'(NPIX - 1));

    // Frame controller. ifm_ready and busy are registered alongside the
    // state so they change on the same edge as the state they describe.
    // The channel/pixel counters only move on accepted beats, so bubbles
    // freeze them. DRAIN waits for the registered done pulse, which marks
    // the final output leaving the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ifm_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            ch          <= '0;
            pix         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        ifm_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ch          <= '0;
                        pix         <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (ch_last) begin
                            ch <= '0;
                            if (pix_last) begin
                                pix         <= '0;
                                state       <= DRAIN;
                                ifm_ready_q <= 1'b0;
                            end else begin
                                pix <= pix + 1'b1;
                            end
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ifm_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane datapath: the next accumulator value for stage 2 and the
    // quantised value of the current accumulator for stage 3.
    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            acc_next[i] = mac_step(acc[i], s1_first, bus.bias[i], s1_ifm, s1_ker[i]);
            q_next[i]   = quantise(acc[i]);
        end
    end

    // Pipeline registers. Only a valid stage-1 beat touches the
    // accumulators, and only a completed pixel (stage-2 last beat) is
    // quantised. Quantising from acc one edge after its final update is
    // safe even back-to-back: the next pixel's first beat overwrites acc on
    // that same edge. The frame-last flag rides along so done lines up with
    // the final strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_frame_last <= 1'b0;
            s1_ifm        <= '0;
            s1_ker        <= '0;
            acc           <= '{default: '0};
            s2_valid      <= 1'b0;
            s2_frame_last <= 1'b0;
            q_reg         <= '0;
            s3_valid      <= 1'b0;
            s3_frame_last <= 1'b0;
            ofm_q         <= '0;
            ofm_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ifm        <= bus.ifm;
                s1_ker        <= bus.rom_data;
                s1_first      <= (ch == '0);
                s1_last       <= ch_last;
                s1_frame_last <= ch_last && pix_last;
            end

            if (s1_valid) begin
                acc <= acc_next;
            end
            s2_valid      <= s1_valid && s1_last;
            s2_frame_last <= s1_valid && s1_last && s1_frame_last;

            if (s2_valid) begin
                q_reg <= q_next;
            end
            s3_valid      <= s2_valid;
            s3_frame_last <= s2_frame_last;

            if (s3_valid) begin
                ofm_q <= q_reg;
            end
            ofm_valid_q <= s3_valid;
            done_q      <= s3_frame_last;
        end
    end

    assign bus.ifm_ready = ifm_ready_q;
    assign bus.rom_addr  = ch;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ofm_valid = ofm_valid_q;
    assign bus.ofm       = ofm_q;

endmodule
